serial_add_ctrl: RTL

- Bit-serial add/subtract controller that time-multiplexes one single-bit full adder cell (FullAdd) across WIDTH-bit operands, LSB first.
- Accepts operands through a valid/ready input handshake and sequences one bit per clock through the shared cell.
- Holds carry state between bits and presents the result through a valid/ready output handshake.
- Sits between a requester (ALU sequencer or testbench driver) and the arithmetic cell, trading latency for area.

---
 rtl/serial_add_ctrl_if.sv | 35 +++
 rtl/serial_add_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl_if
//  Description : Operand/result handshake bundle for the bit-serial
//                add/subtract controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             busy;

    // Requester side: issues operands, consumes results
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, busy
    );

    // Controller side
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow, busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Bit-serial add/subtract controller. One full-adder cell is
//                reused across WIDTH bits, LSB first, one bit per clock.
//                Subtraction is A + ~B + 1 (carry-in preset to 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Bit index of the MSB's carry-in and of the MSB itself
    localparam logic [CNT_W-1:0] c_msbInIdx = CNT_W'(WIDTH - 2);
    localparam logic [CNT_W-1:0] c_lastIdx  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shiftA;
    logic [WIDTH-1:0] r_shiftB;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_count;
    logic             r_carry;
    logic             r_carryMsbIn;
    logic             r_cout;
    logic             r_overflow;
    logic             r_outValid;
    logic             r_busy;

    logic             w_cellS;
    logic             w_cellCout;
    logic             w_accept;

    // Shared full-adder cell fed from the low bits of the shift registers
    always_comb begin
        w_cellS    = r_shiftA[0] ^ r_shiftB[0] ^ r_carry;
        w_cellCout = (r_shiftA[0] & r_shiftB[0]) |
                     (r_carry & (r_shiftA[0] ^ r_shiftB[0]));
    end

    // in_ready is gated by rst_n so it drops the instant reset asserts
    assign bus.in_ready = rst_n && (r_state == ST_IDLE);
    assign w_accept     = bus.in_valid && bus.in_ready;

    assign bus.out_valid = r_outValid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.overflow  = r_overflow;
    assign bus.busy      = r_busy;

    // Control FSM and datapath: load on accept, one bit per RUN edge, hold in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_shiftA     <= '0;
            r_shiftB     <= '0;
            r_sum        <= '0;
            r_count      <= '0;
            r_carry      <= 1'b0;
            r_carryMsbIn <= 1'b0;
            r_cout       <= 1'b0;
            r_overflow   <= 1'b0;
            r_outValid   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shiftA <= bus.a;
                        r_shiftB <= bus.sub ? ~bus.b : bus.b;
                        r_carry  <= bus.sub;
                        r_count  <= '0;
                        r_sum    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    // Result bits enter at the MSB so bit 0 lands at the bottom after WIDTH shifts
                    r_sum    <= {w_cellS, r_sum[WIDTH-1:1]};
                    r_shiftA <= {1'b0, r_shiftA[WIDTH-1:1]};
                    r_shiftB <= {1'b0, r_shiftB[WIDTH-1:1]};
                    r_carry  <= w_cellCout;
                    r_count  <= r_count + 1'b1;
                    if (r_count == c_msbInIdx) begin
                        r_carryMsbIn <= w_cellCout;
                    end
                    if (r_count == c_lastIdx) begin
                        // Signed overflow: carry into MSB differs from carry out of MSB
                        r_cout     <= w_cellCout;
                        r_overflow <= w_cellCout ^ r_carryMsbIn;
                        r_outValid <= 1'b1;
                        r_state    <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_outValid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
